// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer: feeds (sample, coef) pairs to a Booth multiplier and accumulates N products into one DCT sum
module dct_mac_sequencer #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int TIMEOUT = 64,
  localparam int OW = 2 * W + $clog2(N),
  localparam int CW = (N > 1) ? $clog2(N) : 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_sample,
  input  logic signed [W-1:0]  in_coef,
  output logic                 mul_start,
  output logic signed [W-1:0]  mul_data,
  input  logic                 mul_done,
  input  logic [2*W-1:0]       mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 err
);
  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, WAIT, OUT, HALT} state_t;
  state_t state_q, state_d;
  logic signed [W-1:0] coef_q, coef_d, mul_data_q, mul_data_d;
  logic signed [OW-1:0] acc_q, acc_d, out_data_q, out_data_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic mul_start_q, mul_start_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d, err_q, err_d;
  // next state, datapath updates and registered Moore outputs derived from the next state
  always_comb begin
    state_d = state_q;
    coef_d = coef_q;
    mul_data_d = mul_data_q;
    acc_d = acc_q;
    out_data_d = out_data_q;
    cnt_d = cnt_q;
    timer_d = timer_q;
    err_d = err_q;
    sum = acc_q + OW'($signed(mul_product));
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        state_d = LOAD_M;
        coef_d = in_coef;
        mul_data_d = in_sample;
      end
      LOAD_M: begin
        state_d = LOAD_Q;
        mul_data_d = coef_q;
      end
      LOAD_Q: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (mul_done) begin
        acc_d = sum;
        timer_d = '0;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N - 1)) ? OUT : IDLE;
        out_data_d = (cnt_q == CW'(N - 1)) ? sum : out_data_q;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        err_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
        state_d = IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      OUT: if (out_ready) begin
        acc_d = '0;
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mul_start_d = (state_d == LOAD_M);
    in_ready_d = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      coef_q <= '0;
      mul_data_q <= '0;
      acc_q <= '0;
      out_data_q <= '0;
      cnt_q <= '0;
      timer_q <= '0;
      err_q <= 1'b0;
      mul_start_q <= 1'b0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q <= coef_d;
      mul_data_q <= mul_data_d;
      acc_q <= acc_d;
      out_data_q <= out_data_d;
      cnt_q <= cnt_d;
      timer_q <= timer_d;
      err_q <= err_d;
      mul_start_q <= mul_start_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready = in_ready_q;
  assign mul_start = mul_start_q;
  assign mul_data = mul_data_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign err = err_q;
endmodule

// File: tb/tb_dct_mac_sequencer.sv
// tb_dct_mac_sequencer: directed-vector bench with a behavioural multiplier handshake
module tb_dct_mac_sequencer;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, mul_start, mul_done = 1'b0, out_valid, out_ready = 1'b1, err;
  logic signed [15:0] in_sample = '0, in_coef = '0, mul_data;
  logic [31:0] mul_product = '0;
  logic signed [34:0] out_data;
  int nvec = 0, nerr = 0;
  dct_mac_sequencer #(.W(16), .N(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .in_coef(in_coef), .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done),
    .mul_product(mul_product), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pair(input int s, input int c, input int lat, input bit done);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_sample = 16'(s);
    in_coef = 16'(c);
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_m_start", mul_start, 1);
    chk("load_m_data", mul_data, s);
    @(negedge clk);
    chk("load_q_start", mul_start, 0);
    chk("load_q_data", mul_data, c);
    if (done) begin
      repeat (lat) @(negedge clk);
      mul_done = 1'b1;
      mul_product = 32'(s * c);
      @(negedge clk);
      mul_done = 1'b0;
    end else begin
      repeat (TIMEOUT + 4) @(negedge clk);
    end
  endtask
  task automatic frame(input int s[8], input int c[8], input longint exp, input int hold);
    out_ready = (hold == 0);
    for (int i = 0; i < 8; i++) pair(s[i], c[i], (i == 0 && hold > 0) ? 34 : 2 + i, 1'b1);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    chk("in_ready_out", in_ready, 0);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_sample = 16'sd9;
      in_coef = 16'sd9;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, exp);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_no_start", mul_start, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_clr", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_data", mul_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    frame('{14, 1, 2, 3, 4, 5, 6, 7}, '{-16, 2, 2, 2, 2, 2, 2, 2}, -168, 10);
    frame('{1, 2, 3, 4, 5, 6, 7, 8}, '{2, 2, 2, 2, 2, 2, 2, 2}, 72, 0);
    frame('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768},
          '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}, 64'sd8589934592, 0);
    frame('{-3, 7, 100, -1, 0, -32768, 5, 2}, '{5, -2, 100, -1, 9, 32767, 5, -8}, -1073699075, 0);
    pair(1, 1, 3, 1'b1);
    pair(1, 1, 3, 1'b1);
    chk("err_before", err, 0);
    pair(1, 1, 0, 1'b0);
    chk("err_timeout", err, 1);
    chk("in_ready_after_to", in_ready, 1);
    frame('{1, 1, 1, 1, 1, 1, 1, 1}, '{1, 1, 1, 1, 1, 1, 1, 1}, 8, 0);
    chk("err_sticky", err, 1);
    pair(1, 2, 3, 1'b1);
    pair(1, 2, 3, 1'b1);
    in_valid = 1'b1;
    in_sample = 16'sd5;
    in_coef = 16'sd6;
    @(negedge clk);
    chk("pre_rst_start", mul_start, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_start", mul_start, 0);
    chk("arst_data", mul_data, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_err", err, 0);
    chk("arst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mul_done = 1'b1;
    mul_product = 32'd1000;
    @(negedge clk);
    mul_done = 1'b0;
    chk("spurious_done_state", in_ready, 1);
    frame('{1, 2, 3, 4, 5, 6, 7, 8}, '{3, 3, 3, 3, 3, 3, 3, 3}, 108, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
